// File: rtl/alu_result_buffer_if.sv
// Handshake bundle between the ALU stage, the result buffer and the memory stage.
// The slave side is the buffer; the master side is whatever drives it (upstream and downstream together).
interface alu_result_buffer_if #(
   parameter int W = 32
);
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_z;
   logic         in_zero;
   logic [4:0]   in_rd;
   logic         in_wb;
   logic         in_br;

   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_z;
   logic         out_zero;
   logic [4:0]   out_rd;
   logic         out_wb;
   logic         out_taken;

   modport master (
      output in_valid, in_z, in_zero, in_rd, in_wb, in_br, out_ready,
      input  in_ready, out_valid, out_z, out_zero, out_rd, out_wb, out_taken
   );

   modport slave (
      input  in_valid, in_z, in_zero, in_rd, in_wb, in_br, out_ready,
      output in_ready, out_valid, out_z, out_zero, out_rd, out_wb, out_taken
   );
endinterface

// File: rtl/alu_result_buffer.sv
// Two-entry FIFO between execute and memory: holds ALU results across memory-stage stalls
// and counts retired entries.
module alu_result_buffer #(
   parameter int W  = 32,
   parameter int CW = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   alu_result_buffer_if.slave   bus,
   output logic [CW-1:0]        retire_cnt
);

   typedef struct packed {
      logic [W-1:0] z;
      logic         zero;
      logic [4:0]   rd;
      logic         wb;
      logic         br;
   } entry_t;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t state;
   state_t state_next;
   entry_t slot0;
   entry_t slot1;
   entry_t slot0_next;
   entry_t slot1_next;
   entry_t in_entry;
   logic   push;
   logic   pop;

   // Handshake flags come only from registered occupancy, keeping ready/valid free of combinational loops.
   assign bus.in_ready  = (state != FULL);
   assign bus.out_valid = (state != EMPTY);
   assign push          = bus.in_valid & bus.in_ready;
   assign pop           = bus.out_valid & bus.out_ready;

   assign in_entry = '{z: bus.in_z, zero: bus.in_zero, rd: bus.in_rd, wb: bus.in_wb, br: bus.in_br};

   assign bus.out_z     = slot0.z;
   assign bus.out_zero  = slot0.zero;
   assign bus.out_rd    = slot0.rd;
   assign bus.out_wb    = slot0.wb;
   assign bus.out_taken = bus.out_valid & slot0.br & slot0.zero;

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= EMPTY;
         slot0      <= '0;
         slot1      <= '0;
         retire_cnt <= '0;
      end else begin
         state <= state_next;
         slot0 <= slot0_next;
         slot1 <= slot1_next;
         if (pop) begin
            retire_cnt <= retire_cnt + CW'(1);
         end
      end
   end

   // In ONE with simultaneous push and pop the new entry replaces the head directly.
   always_comb begin
      state_next = state;
      slot0_next = slot0;
      slot1_next = slot1;
      case (state)
         EMPTY: begin
            if (push) begin
               state_next = ONE;
               slot0_next = in_entry;
            end
         end
         ONE: begin
            if (push && pop) begin
               slot0_next = in_entry;
            end else if (push) begin
               state_next = FULL;
               slot1_next = in_entry;
            end else if (pop) begin
               state_next = EMPTY;
            end
         end
         FULL: begin
            if (pop) begin
               state_next = ONE;
               slot0_next = slot1;
            end
         end
         default: begin
            state_next = EMPTY;
         end
      endcase
   end

endmodule

// File: doc/alu_result_buffer.md
# alu_result_buffer

Two-entry registered buffer directly downstream of the 32-bit ALU, in the execute-to-memory boundary of the datapath. It captures the ALU result `z`, the `zero` flag and the instruction's write-back/branch tags under a valid/ready handshake. It holds them until the memory stage accepts them, so a memory-stage stall never forces the ALU to re-evaluate. It also keeps a wrap-around count of results retired to the memory stage.

## Interface
- `W`, 32, width of the ALU result path
- `CW`, 16, width of the retire counter

- `clk`  in  1  single clock, all state updates on rising edge
- `reset`  in  1  synchronous, active-high; sampled on rising edge of `clk`
- `in_valid`  in  1  ALU stage presents a result this cycle
- `in_ready`  out  1  buffer can accept a result this cycle
- `in_z`  in  W  ALU result
- `in_zero`  in  1  ALU zero flag (1 when `in_z` == 0)
- `in_rd`  in  5  destination register index
- `in_wb`  in  1  result is to be written back
- `in_br`  in  1  instruction is a conditional branch (beq-style)
- `out_valid`  out  1  head entry valid
- `out_ready`  in  1  memory stage accepts head entry this cycle
- `out_z`  out  W  head entry result
- `out_zero`  out  1  head entry zero flag
- `out_rd`  out  5  head entry destination index
- `out_wb`  out  1  head entry write-back tag
- `out_taken`  out  1  `out_valid & out_br & out_zero`, where `out_br` is the stored branch tag
- `retire_cnt`  out  CW  number of entries popped since reset, modulo 2^CW

## Operation
- Storage: two entries (slot 0 = head, slot 1 = tail), each holding {z, zero, rd, wb, br}.
- Occupancy `count` takes the values 0, 1 or 2. This is the state machine: EMPTY(0), ONE(1), FULL(2).
- Handshake:
  - push = `in_valid & in_ready`
  - pop = `out_valid & out_ready`
- `in_ready` = (count != 2); `out_valid` = (count != 0). Both are decoded from registered state only, with no combinational path from `out_ready` or `in_valid`.
- Transitions:
  - EMPTY: push → ONE (slot 0 ← input).
  - ONE, push only → FULL (slot 1 ← input).
  - ONE, pop only → EMPTY.
  - ONE, push+pop → stays ONE (slot 0 ← input).
  - FULL, pop → ONE (slot 0 ← slot 1). Push cannot occur in FULL because `in_ready`=0.
- Order is strict FIFO. An entry never bypasses storage: data presented at cycle t appears on the outputs no earlier than t+1.
- Outputs `out_z`/`out_zero`/`out_rd`/`out_wb` reflect slot 0 regardless of `out_valid`. Their value is don't-care when `out_valid`=0, except after reset.
- `out_taken` is gated by `out_valid`, so it is never 1 while empty.
- `retire_cnt` increments by 1 on each pop and wraps from 2^CW−1 to 0.
- `in_zero` is stored as given; the buffer does not recompute it from `in_z`.

## Timing
- Reset (synchronous, `reset`=1 at a rising edge): count ← 0, both slots ← 0, `retire_cnt` ← 0.
- Reset values of outputs on the following cycle:
  - `out_valid`=0, `in_ready`=1
  - `out_z`=0, `out_zero`=0, `out_rd`=0, `out_wb`=0, `out_taken`=0
  - `retire_cnt`=0
- Reset has priority over a simultaneous push or pop. An in-flight handshake in the reset cycle is discarded and not counted.
- Latency: push at edge t → `out_valid`=1 at t+1.
- Throughput: one entry per cycle sustained while `out_ready`=1 (ONE with push+pop).
- Back-pressure: two results absorbed after `out_ready` drops. `in_ready` falls the cycle after the second push.
- Recovery from FULL: after a pop from FULL, `in_ready`=1 in the next cycle.
- The upstream stage must hold `in_*` stable while `in_valid`=1 and `in_ready`=0. The buffer does not check this.

## Test plan
- Reset then idle: after `reset`=1 for one edge → `out_valid`=0, `in_ready`=1, `retire_cnt`=0, `out_taken`=0. This also holds when reset is asserted while FULL.
- Single pass: push z=0x0000_0005, zero=0, rd=3, wb=1 with `out_ready`=1 →
  - next cycle: `out_valid`=1, `out_z`=5, `out_rd`=3
  - the cycle after: `out_valid`=0, `retire_cnt`=1
- Back-pressure: `out_ready`=0, push 0xA, 0xB, then offer 0xC →
  - `in_ready`=0 after the second push; 0xC is held by upstream
  - raise `out_ready`: outputs appear in order 0xA, 0xB, 0xC; `retire_cnt`=3
- Streaming: push 100 consecutive values 0..99 with `out_ready`=1 → one output per cycle in order, `in_ready` constantly 1, `retire_cnt`=100.
- Branch flag:
  - push br=1, zero=1 → `out_taken`=1 only while that entry is head and valid
  - push br=1, zero=0 → `out_taken`=0
  - push br=0, zero=1 → `out_taken`=0
- Counter wrap: with `CW`=4, perform 17 pops → `retire_cnt`=1.
